// File: rtl/bomberman_pkg.sv
// Shared constants and types for the bomberman datapath: screen geometry,
// ROM bank codes, the transparent colour and the draw_engine state encoding.
package bomberman_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int TILE     = 16;
    localparam int COLOUR_W = 9;

    localparam logic [COLOUR_W-1:0] KEY_COLOUR = 9'h1C7;

    typedef enum logic [1:0] {
        MS_TITLE = 2'd0,
        MS_STAGE = 2'd1,
        MS_WIN   = 2'd2,
        MS_TILE  = 2'd3
    } mem_sel_e;

    typedef enum logic [1:0] {
        DE_IDLE  = 2'd0,
        DE_RUN   = 2'd1,
        DE_DRAIN = 2'd2,
        DE_DONE  = 2'd3
    } de_state_e;

    // Job parameters captured when a draw request is accepted.
    typedef struct packed {
        logic [1:0] ms;
        logic [3:0] sprite;
        logic [7:0] x0;
        logic [6:0] y0;
        logic       black;
    } job_t;

endpackage

// File: rtl/pixel_scanner.sv
// Raster col/row counter with programmable width/height; shared by the
// draw engine and the print-to-VGA path.
module pixel_scanner (
    input  logic       clock,
    input  logic       resetn,
    input  logic       clear,
    input  logic       advance,
    input  logic [7:0] w,
    input  logic [6:0] h,
    output logic [7:0] col,
    output logic [6:0] row,
    output logic       last
);

    logic [7:0] col_q, col_d;
    logic [6:0] row_q, row_d;
    logic       wrap;

    assign wrap = (col_q == w - 8'd1);
    assign last = wrap && (row_q == h - 7'd1);
    assign col  = col_q;
    assign row  = row_q;

    always_comb begin
        // NOTE: hold-value defaults first, so no path through this block leaves a latch.
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            if (wrap) begin
                col_d = '0;
                row_d = last ? 7'd0 : row_q + 7'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!resetn) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/draw_engine.sv
// Copies a full-screen background or one 16x16 tile from ROM into the frame
// buffer while copy_enable is held, then pulses finished for one cycle.
module draw_engine
    import bomberman_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic                copy_enable,
    input  logic [1:0]          memory_select,
    input  logic [3:0]          sprite_id,
    input  logic [7:0]          dest_x,
    input  logic [6:0]          dest_y,
    input  logic                black,
    output logic [1:0]          src_bank,
    output logic [14:0]         src_addr,
    output logic                src_rd,
    input  logic [COLOUR_W-1:0] src_data,
    output logic [7:0]          fb_x,
    output logic [6:0]          fb_y,
    output logic [COLOUR_W-1:0] fb_colour,
    output logic                fb_we,
    output logic                busy,
    output logic                finished
);

    de_state_e  state_q, state_d;
    job_t       job_q, job_d;
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wcol_q, wcol_d;
    logic [6:0] wrow_q, wrow_d;

    logic       accept, run, tile, last;
    logic [7:0] col, w;
    logic [6:0] row, h;
    logic [14:0] base, offset;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       clipped, keyed;

    assign accept = (state_q == DE_IDLE) && copy_enable;
    assign run    = (state_q == DE_RUN);
    assign tile   = (job_q.ms == MS_TILE);
    assign w      = tile ? 8'(TILE) : 8'(SCREEN_W);
    assign h      = tile ? 7'(TILE) : 7'(SCREEN_H);
    assign base   = {3'b000, job_q.sprite, 8'h00};
    assign offset = 15'(row) * 15'(w) + 15'(col);

    pixel_scanner u_scanner (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (accept),
        .advance (run),
        .w       (w),
        .h       (h),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= DE_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DE_IDLE:  if (copy_enable) state_d = DE_RUN;
            DE_RUN:   if (!copy_enable) state_d = DE_IDLE;
                      else if (last)    state_d = DE_DRAIN;
            DE_DRAIN: state_d = copy_enable ? DE_DONE : DE_IDLE;
            DE_DONE:  state_d = DE_IDLE;
            default:  state_d = DE_IDLE;
        endcase
    end

    // Full-screen jobs latch a zero origin/sprite so the datapath needs no mode muxes.
    always_comb begin
        job_d = job_q;
        if (accept) begin
            job_d.ms     = memory_select;
            job_d.sprite = (memory_select == MS_TILE) ? sprite_id : 4'd0;
            job_d.x0     = (memory_select == MS_TILE) ? dest_x    : 8'd0;
            job_d.y0     = (memory_select == MS_TILE) ? dest_y    : 7'd0;
            job_d.black  = (memory_select == MS_TILE) && black;
        end
        wr_valid_d = run && copy_enable;
        wcol_d     = col;
        wrow_d     = row;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            job_q      <= '0;
            wr_valid_q <= 1'b0;
            wcol_q     <= '0;
            wrow_q     <= '0;
        end else begin
            job_q      <= job_d;
            wr_valid_q <= wr_valid_d;
            wcol_q     <= wcol_d;
            wrow_q     <= wrow_d;
        end
    end

    // One extra bit on the coordinate sums so off-screen pixels clip instead of wrapping.
    assign sum_x   = {1'b0, job_q.x0} + {1'b0, wcol_q};
    assign sum_y   = {1'b0, job_q.y0} + {1'b0, wrow_q};
    assign clipped = (sum_x >= 9'(SCREEN_W)) || (sum_y >= 8'(SCREEN_H));
    assign keyed   = tile && !job_q.black && (src_data == KEY_COLOUR);

    // A dropped copy_enable kills the write already in the pipeline.
    always_comb begin
        src_bank  = job_q.ms;
        src_rd    = run;
        src_addr  = run ? base + offset : '0;
        fb_x      = wr_valid_q ? sum_x[7:0] : '0;
        fb_y      = wr_valid_q ? sum_y[6:0] : '0;
        fb_colour = (wr_valid_q && !job_q.black) ? src_data : '0;
        fb_we     = wr_valid_q && copy_enable && !keyed && !clipped;
        busy      = (state_q == DE_RUN) || (state_q == DE_DRAIN);
        finished  = (state_q == DE_DONE);
    end

endmodule

// File: tb/tb_draw_engine.sv
// Directed bench for draw_engine: ROM model, in-order frame-buffer write model
// and per-scenario checks of counts, addresses and finished timing.
module tb_draw_engine;

    logic        clock, resetn, copy_enable, black;
    logic [1:0]  memory_select;
    logic [3:0]  sprite_id;
    logic [7:0]  dest_x;
    logic [6:0]  dest_y;
    logic [1:0]  src_bank;
    logic [14:0] src_addr;
    logic        src_rd;
    logic [8:0]  src_data;
    logic [7:0]  fb_x;
    logic [6:0]  fb_y;
    logic [8:0]  fb_colour;
    logic        fb_we, busy, finished;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int fin_cnt;
        int fin_cycle;
        int first_rd;
        int rd_cnt;
        int writes;
        int write_errs;
        int addr_errs;
        int busy_errs;
        int bank_errs;
        int after_stop;
        int inflight_we;
        int probe_hits;
        int colour_nz;
    } stats_t;

    draw_engine dut (
        .clock         (clock),
        .resetn        (resetn),
        .copy_enable   (copy_enable),
        .memory_select (memory_select),
        .sprite_id     (sprite_id),
        .dest_x        (dest_x),
        .dest_y        (dest_y),
        .black         (black),
        .src_bank      (src_bank),
        .src_addr      (src_addr),
        .src_rd        (src_rd),
        .src_data      (src_data),
        .fb_x          (fb_x),
        .fb_y          (fb_y),
        .fb_colour     (fb_colour),
        .fb_we         (fb_we),
        .busy          (busy),
        .finished      (finished)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ROM contents: address pattern, with word 514 forced to the key colour.
    function automatic logic [8:0] rom_word(input logic [14:0] a);
        logic [8:0] r;
        r = a[8:0] ^ 9'h0A5;
        if (a == 15'd514) r = 9'h1C7;
        return r;
    endfunction

    always @(posedge clock) src_data <= src_rd ? rom_word(src_addr) : 9'h0AA;

    function automatic void model_px(input bit tile, input bit blk, input int base,
                                     input int dx, input int dy, input int w, input int k,
                                     output bit wr, output int ex, output int ey,
                                     output logic [8:0] ec);
        logic [8:0] d;
        d  = rom_word(15'(base + k));
        ex = dx + k % w;
        ey = dy + k / w;
        ec = (tile && blk) ? 9'd0 : d;
        wr = !(tile && !blk && d == 9'h1C7) && ex < 160 && ey < 120;
    endfunction

    // Runs one job starting at a negedge; lead = idle cycles before the accept edge.
    task automatic run_job(input logic [1:0] ms, input logic [3:0] sid, input logic [7:0] dx,
                           input logic [6:0] dy, input logic blk, input int lead,
                           input int abort_at, input bit keep, input int px, input int py,
                           output stats_t s);
        bit tile, wr;
        int w, npix, base, k, stop_n, ex, ey, mdx, mdy;
        logic [8:0] ec;
        logic exp_rd, exp_busy;
        tile = (ms == 2'd3);
        w    = tile ? 16 : 160;
        npix = tile ? 256 : 19200;
        base = tile ? int'(sid) * 256 : 0;
        mdx  = tile ? int'(dx) : 0;
        mdy  = tile ? int'(dy) : 0;
        s = '{default: 0};
        s.fin_cycle = -1;
        s.first_rd  = -1;
        k = 0;
        stop_n = 0;
        memory_select = ms; sprite_id = sid; dest_x = dx; dest_y = dy; black = blk;
        copy_enable = 1'b1;
        for (int n = 1 - lead; n <= npix + 12; n++) begin
            @(negedge clock);
            if (finished === 1'b1) begin
                s.fin_cnt++;
                if (s.fin_cycle < 0) s.fin_cycle = n;
            end
            if (src_rd === 1'b1) begin
                s.rd_cnt++;
                if (s.first_rd < 0) s.first_rd = n;
            end
            exp_rd   = (n >= 1) && (n <= npix) && (stop_n == 0 || n <= stop_n);
            exp_busy = (n >= 1) && (n <= npix + 1) && (stop_n == 0 || n <= stop_n);
            if (src_rd !== exp_rd || (exp_rd && src_addr !== 15'(base + n - 1))) s.addr_errs++;
            if (busy !== exp_busy) s.busy_errs++;
            if (exp_busy && src_bank !== ms) s.bank_errs++;
            if (fb_we === 1'b1) begin
                s.writes++;
                if (stop_n != 0 && n > stop_n) s.after_stop++;
                if (int'(fb_x) == px && int'(fb_y) == py) s.probe_hits++;
                if (fb_colour !== 9'd0) s.colour_nz++;
                while (k < npix) begin
                    model_px(tile, blk, base, mdx, mdy, w, k, wr, ex, ey, ec);
                    if (wr) break;
                    k++;
                end
                if (k >= npix) s.write_errs++;
                else if (k != n - 2 || fb_x !== 8'(ex) || fb_y !== 7'(ey) || fb_colour !== ec)
                    s.write_errs++;
                k++;
            end
            if (n == 1) begin
                memory_select = ~ms; sprite_id = ~sid; dest_x = ~dx; dest_y = ~dy; black = ~blk;
            end
            if (abort_at != 0 && n == abort_at) begin
                copy_enable = 1'b0;
                stop_n = n;
                #1;
                s.inflight_we = (fb_we !== 1'b0) ? 1 : 0;
            end
            if (finished === 1'b1 && stop_n == 0) begin
                if (keep) break;
                copy_enable = 1'b0;
                stop_n = n;
            end
            if (stop_n != 0 && n >= stop_n + 4) break;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1; copy_enable = 1'b0; memory_select = 2'd0; sprite_id = 4'd0;
        dest_x = 8'd0; dest_y = 7'd0; black = 1'b0;
        #2 resetn = 1'b0;
        @(negedge clock);
        vectors++;
        if ({src_bank, src_addr, src_rd} !== '0) begin
            miscompares++;
            $display("FAIL reset_src: got bank=%0d addr=%0d rd=%0b want 0", src_bank, src_addr, src_rd);
        end
        vectors++;
        if ({fb_x, fb_y, fb_colour, fb_we} !== '0) begin
            miscompares++;
            $display("FAIL reset_fb: got x=%0d y=%0d c=%0h we=%0b want 0", fb_x, fb_y, fb_colour, fb_we);
        end
        vectors++;
        if ({busy, finished} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_status: got busy=%0b finished=%0b want 0", busy, finished);
        end
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_full_screen();
        stats_t s;
        run_job(2'd1, 4'd0, 8'd0, 7'd0, 1'b0, 0, 0, 1'b0, -1, -1, s);
        vectors++; if (s.writes !== 19200) begin miscompares++; $display("FAIL full_writes: got %0d want 19200", s.writes); end
        vectors++; if (s.rd_cnt !== 19200) begin miscompares++; $display("FAIL full_reads: got %0d want 19200", s.rd_cnt); end
        vectors++; if (s.addr_errs !== 0) begin miscompares++; $display("FAIL full_addr: got %0d bad cycles want 0", s.addr_errs); end
        vectors++; if (s.write_errs !== 0) begin miscompares++; $display("FAIL full_raster: got %0d bad writes want 0", s.write_errs); end
        vectors++; if (s.fin_cycle !== 19202) begin miscompares++; $display("FAIL full_fin_cycle: got %0d want 19202", s.fin_cycle); end
        vectors++; if (s.fin_cnt !== 1) begin miscompares++; $display("FAIL full_fin_cnt: got %0d want 1", s.fin_cnt); end
        vectors++; if (s.busy_errs !== 0) begin miscompares++; $display("FAIL full_busy: got %0d bad cycles want 0", s.busy_errs); end
        vectors++; if (s.bank_errs !== 0) begin miscompares++; $display("FAIL full_bank: got %0d bad cycles want 0", s.bank_errs); end
    endtask

    task automatic test_tile_transparency();
        stats_t s;
        run_job(2'd3, 4'd2, 8'd32, 7'd48, 1'b0, 0, 0, 1'b0, 34, 48, s);
        vectors++; if (s.writes !== 255) begin miscompares++; $display("FAIL tile_writes: got %0d want 255", s.writes); end
        vectors++; if (s.probe_hits !== 0) begin miscompares++; $display("FAIL tile_key_pixel: got %0d writes at (34,48) want 0", s.probe_hits); end
        vectors++; if (s.addr_errs !== 0) begin miscompares++; $display("FAIL tile_addr: got %0d bad cycles want 0", s.addr_errs); end
        vectors++; if (s.write_errs !== 0) begin miscompares++; $display("FAIL tile_pixels: got %0d bad writes want 0", s.write_errs); end
        vectors++; if (s.fin_cycle !== 258) begin miscompares++; $display("FAIL tile_fin_cycle: got %0d want 258", s.fin_cycle); end
        vectors++; if (s.bank_errs !== 0) begin miscompares++; $display("FAIL tile_bank: got %0d bad cycles want 0", s.bank_errs); end
    endtask

    task automatic test_black_tile();
        stats_t s;
        run_job(2'd3, 4'd2, 8'd0, 7'd112, 1'b1, 0, 0, 1'b0, 2, 112, s);
        vectors++; if (s.writes !== 128) begin miscompares++; $display("FAIL black_writes: got %0d want 128", s.writes); end
        vectors++; if (s.colour_nz !== 0) begin miscompares++; $display("FAIL black_colour: got %0d nonzero writes want 0", s.colour_nz); end
        vectors++; if (s.probe_hits !== 1) begin miscompares++; $display("FAIL black_key_pixel: got %0d writes at (2,112) want 1", s.probe_hits); end
        vectors++; if (s.write_errs !== 0) begin miscompares++; $display("FAIL black_pixels: got %0d bad writes want 0", s.write_errs); end
        vectors++; if (s.fin_cycle !== 258) begin miscompares++; $display("FAIL black_fin_cycle: got %0d want 258", s.fin_cycle); end
    endtask

    task automatic test_clip_x();
        stats_t s;
        run_job(2'd3, 4'd1, 8'd152, 7'd10, 1'b0, 0, 0, 1'b0, 167, 10, s);
        vectors++; if (s.writes !== 127) begin miscompares++; $display("FAIL clipx_writes: got %0d want 127", s.writes); end
        vectors++; if (s.write_errs !== 0) begin miscompares++; $display("FAIL clipx_pixels: got %0d bad writes want 0", s.write_errs); end
    endtask

    task automatic test_back_to_back();
        stats_t s1, s2;
        run_job(2'd3, 4'd4, 8'd64, 7'd32, 1'b0, 0, 0, 1'b1, -1, -1, s1);
        run_job(2'd3, 4'd5, 8'd80, 7'd32, 1'b0, 1, 0, 1'b0, -1, -1, s2);
        vectors++; if (s1.fin_cnt !== 1) begin miscompares++; $display("FAIL b2b_fin1_cnt: got %0d want 1", s1.fin_cnt); end
        vectors++; if (s1.writes !== 256) begin miscompares++; $display("FAIL b2b_writes1: got %0d want 256", s1.writes); end
        vectors++; if (s2.first_rd !== 1) begin miscompares++; $display("FAIL b2b_restart: got first src_rd %0d cycles after finished+1 want 1", s2.first_rd); end
        vectors++; if (s2.fin_cnt !== 1) begin miscompares++; $display("FAIL b2b_fin2_cnt: got %0d want 1", s2.fin_cnt); end
        vectors++; if (s2.fin_cycle !== 258) begin miscompares++; $display("FAIL b2b_fin2_cycle: got %0d want 258", s2.fin_cycle); end
        vectors++; if (s2.writes !== 255) begin miscompares++; $display("FAIL b2b_writes2: got %0d want 255", s2.writes); end
        vectors++; if (s2.addr_errs + s2.write_errs !== 0) begin miscompares++; $display("FAIL b2b_job2_data: got %0d errors want 0", s2.addr_errs + s2.write_errs); end
    endtask

    task automatic test_abort();
        stats_t s;
        run_job(2'd1, 4'd0, 8'd0, 7'd0, 1'b0, 0, 100, 1'b0, -1, -1, s);
        vectors++; if (s.fin_cnt !== 0) begin miscompares++; $display("FAIL abort_fin: got %0d pulses want 0", s.fin_cnt); end
        vectors++; if (s.writes !== 99) begin miscompares++; $display("FAIL abort_writes: got %0d want 99", s.writes); end
        vectors++; if (s.rd_cnt !== 100) begin miscompares++; $display("FAIL abort_reads: got %0d want 100", s.rd_cnt); end
        vectors++; if (s.inflight_we !== 0) begin miscompares++; $display("FAIL abort_inflight: got we=%0d want 0", s.inflight_we); end
        vectors++; if (s.after_stop !== 0) begin miscompares++; $display("FAIL abort_late_writes: got %0d want 0", s.after_stop); end
        vectors++; if (s.busy_errs + s.addr_errs !== 0) begin miscompares++; $display("FAIL abort_idle: got %0d bad cycles want 0", s.busy_errs + s.addr_errs); end
    endtask

    task automatic test_reset_mid_job();
        stats_t s;
        memory_select = 2'd3; sprite_id = 4'd3; dest_x = 8'd16; dest_y = 7'd16; black = 1'b0;
        copy_enable = 1'b1;
        repeat (50) @(negedge clock);
        resetn = 1'b0;
        #1;
        vectors++;
        if ({src_bank, src_addr, src_rd} !== '0) begin
            miscompares++;
            $display("FAIL midreset_src: got bank=%0d addr=%0d rd=%0b want 0", src_bank, src_addr, src_rd);
        end
        vectors++;
        if ({fb_x, fb_y, fb_colour, fb_we} !== '0) begin
            miscompares++;
            $display("FAIL midreset_fb: got x=%0d y=%0d c=%0h we=%0b want 0", fb_x, fb_y, fb_colour, fb_we);
        end
        vectors++;
        if ({busy, finished} !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset_status: got busy=%0b finished=%0b want 0", busy, finished);
        end
        copy_enable = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        run_job(2'd3, 4'd3, 8'd16, 7'd16, 1'b0, 0, 0, 1'b0, -1, -1, s);
        vectors++; if (s.first_rd !== 1) begin miscompares++; $display("FAIL midreset_restart: got first src_rd cycle %0d want 1", s.first_rd); end
        vectors++; if (s.addr_errs !== 0) begin miscompares++; $display("FAIL midreset_addr: got %0d bad cycles want 0", s.addr_errs); end
        vectors++; if (s.writes !== 255) begin miscompares++; $display("FAIL midreset_writes: got %0d want 255", s.writes); end
        vectors++; if (s.fin_cnt !== 1) begin miscompares++; $display("FAIL midreset_fin: got %0d pulses want 1", s.fin_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_screen();
        test_tile_transparency();
        test_black_tile();
        test_clip_x();
        test_back_to_back();
        test_abort();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
